// File: rtl/conv_frame_ctrl.sv
// Frame controller that streams one image through an external 3x3 convolution
// accelerator, counts pixels in and results out, and guards against stalls.
module conv_frame_ctrl #(
   parameter int IMG_W   = 24,
   parameter int IMG_H   = 24,
   parameter int PIXW    = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [71:0]     filt,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [PIXW-1:0] s_x,
   output logic [71:0]     acc_f,
   output logic            acc_i_valid,
   input  logic            acc_i_ready,
   output logic [PIXW-1:0] acc_i_x,
   input  logic            acc_o_valid,
   output logic            acc_o_ready,
   input  logic [PIXW-1:0] acc_o_y,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [PIXW-1:0] m_y,
   output logic            m_last,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [15:0]     frame_cnt
);

   localparam int N_IN   = IMG_W * IMG_H;
   localparam int N_OUT  = (IMG_W - 2) * (IMG_H - 2);
   localparam int IN_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int OUT_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [IN_W-1:0]   IN_LAST   = IN_W'(N_IN - 1);
   localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(N_OUT - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   state_t              state_reg, state_next;
   logic [71:0]         f_q_reg;
   logic [IN_W-1:0]     in_cnt_reg;
   logic [OUT_W-1:0]    out_cnt_reg;
   logic [IDLE_W-1:0]   idle_cnt_reg;
   logic                err_reg;
   logic [15:0]         frame_cnt_reg;

   logic in_phase, out_phase, in_xfer, out_xfer;
   logic in_final, out_final, stall, timed_out;

   assign in_phase  = (state_reg == STREAM);
   assign out_phase = (state_reg == STREAM) || (state_reg == DRAIN);
   assign in_xfer   = in_phase & s_valid & acc_i_ready;
   assign out_xfer  = out_phase & acc_o_valid & m_ready;
   assign in_final  = in_xfer && (in_cnt_reg == IN_LAST);
   assign out_final = out_xfer && (out_cnt_reg == OUT_LAST);
   assign stall     = out_phase & ~in_xfer & ~out_xfer;
   assign timed_out = stall && (idle_cnt_reg == IDLE_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Abort wins over everything; the final result wins over a simultaneous last pixel.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = STREAM;
         STREAM: begin
            if (abort)                       state_next = IDLE;
            else if (out_final || timed_out) state_next = DONE;
            else if (in_final)               state_next = DRAIN;
         end
         DRAIN: begin
            if (abort)                       state_next = IDLE;
            else if (out_final || timed_out) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         f_q_reg       <= '0;
         in_cnt_reg    <= '0;
         out_cnt_reg   <= '0;
         idle_cnt_reg  <= '0;
         err_reg       <= 1'b0;
         frame_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  f_q_reg      <= filt;
                  in_cnt_reg   <= '0;
                  out_cnt_reg  <= '0;
                  idle_cnt_reg <= '0;
                  err_reg      <= 1'b0;
               end
            end
            STREAM, DRAIN: begin
               if (!abort) begin
                  if (in_xfer)  in_cnt_reg  <= in_cnt_reg + IN_W'(1);
                  if (out_xfer) out_cnt_reg <= out_cnt_reg + OUT_W'(1);
                  if (in_xfer || out_xfer) idle_cnt_reg <= '0;
                  else if (!timed_out)     idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
                  if (timed_out) err_reg <= 1'b1;
               end
            end
            DONE:    frame_cnt_reg <= frame_cnt_reg + 16'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      s_ready     = 1'b0;
      acc_i_valid = 1'b0;
      acc_i_x     = '0;
      m_valid     = 1'b0;
      acc_o_ready = 1'b0;
      m_y         = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state_reg)
         STREAM: begin
            s_ready     = acc_i_ready;
            acc_i_valid = s_valid;
            acc_i_x     = s_x;
            m_valid     = acc_o_valid;
            acc_o_ready = m_ready;
            m_y         = acc_o_y;
            busy        = 1'b1;
         end
         DRAIN: begin
            m_valid     = acc_o_valid;
            acc_o_ready = m_ready;
            m_y         = acc_o_y;
            busy        = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
      m_last = m_valid && (out_cnt_reg == OUT_LAST);
   end

   assign acc_f     = f_q_reg;
   assign err       = err_reg;
   assign frame_cnt = frame_cnt_reg;

endmodule
